// File: rtl/uart_pkg.sv
// UART receiver shared definitions: baud table, divisor helper,
// parity encodings and receiver FSM states.
package uart_pkg;

    localparam logic [1:0] PAR_NONE = 2'b00;
    localparam logic [1:0] PAR_EVEN = 2'b01;
    localparam logic [1:0] PAR_ODD  = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PARITY,
        S_STOP
    } rx_state_t;

    function automatic int unsigned baud_rate(input logic [2:0] idx);
        int unsigned b;
        unique case (idx)
            3'd0: b = 300;
            3'd1: b = 1200;
            3'd2: b = 4800;
            3'd3: b = 9600;
            3'd4: b = 19200;
            3'd5: b = 38400;
            3'd6: b = 57600;
            3'd7: b = 115200;
        endcase
        return b;
    endfunction

    // Clocks per 16x sample tick, rounded to nearest.
    function automatic int unsigned baud_div(input int unsigned clk_hz,
                                             input logic [2:0] idx);
        int unsigned b;
        b = baud_rate(idx);
        return (clk_hz + 8 * b) / (16 * b);
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Show-ahead synchronous FIFO with sticky overrun flag.
// Ports: i_wr_en/i_wr_data push, i_rd_en pop, i_clr_overrun;
//        o_rd_data head, o_empty, o_full, o_count, o_overrun.
module sync_fifo #(
    parameter int WIDTH = 10,
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     i_wr_en,
    input  logic [WIDTH-1:0]         i_wr_data,
    input  logic                     i_rd_en,
    input  logic                     i_clr_overrun,
    output logic [WIDTH-1:0]         o_rd_data,
    output logic                     o_empty,
    output logic                     o_full,
    output logic [$clog2(DEPTH):0]   o_count,
    output logic                     o_overrun
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [AW:0]      r_count;
    logic             r_overrun;
    logic             w_full;
    logic             w_empty;
    logic             w_pop;
    logic             w_push;
    logic             w_drop;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == (AW+1)'(DEPTH));
    assign w_pop   = i_rd_en && !w_empty;
    // A pop frees the slot in the same edge, so full+pop still accepts.
    assign w_push  = i_wr_en && (!w_full || w_pop);
    assign w_drop  = i_wr_en && w_full && !w_pop;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_count   <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            if (w_push && !w_pop) begin
                r_count <= r_count + 1'b1;
            end else if (w_pop && !w_push) begin
                r_count <= r_count - 1'b1;
            end
            if (w_drop) begin
                r_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                r_overrun <= 1'b0;
            end
        end
    end

    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_empty   = w_empty;
    assign o_full    = w_full;
    assign o_count   = r_count;
    assign o_overrun = r_overrun;

endmodule

// File: rtl/uart_receiver_fifo.sv
// UART receiver (16x oversampling) feeding a show-ahead FIFO.
// Ports: RxD serial in, baud_select, RX_EN; rd_en/clr_overrun host side;
//        Rx_DATA/Rx_FERROR/Rx_PERROR head entry, FIFO status, Rx_OVERRUN.
module uart_receiver_fifo
    import uart_pkg::*;
#(
    parameter int unsigned CLK_HZ      = 50_000_000,
    parameter int          DATA_BITS   = 8,
    parameter logic [1:0]  PARITY_MODE = 2'b01,
    parameter int          STOP_BITS   = 1,
    parameter int          DEPTH       = 8
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [2:0]             baud_select,
    input  logic                   RX_EN,
    input  logic                   RxD,
    input  logic                   rd_en,
    input  logic                   clr_overrun,
    output logic [DATA_BITS-1:0]   Rx_DATA,
    output logic                   Rx_FERROR,
    output logic                   Rx_PERROR,
    output logic                   Rx_EMPTY,
    output logic                   Rx_FULL,
    output logic [$clog2(DEPTH):0] Rx_COUNT,
    output logic                   Rx_OVERRUN
);

    localparam int DIVW  = $clog2(baud_div(CLK_HZ, 3'd0) + 1);
    localparam int BW    = $clog2(DATA_BITS);
    localparam int WIDTH = DATA_BITS + 2;

    localparam int unsigned DIV_TBL [8] = '{
        baud_div(CLK_HZ, 3'd0), baud_div(CLK_HZ, 3'd1),
        baud_div(CLK_HZ, 3'd2), baud_div(CLK_HZ, 3'd3),
        baud_div(CLK_HZ, 3'd4), baud_div(CLK_HZ, 3'd5),
        baud_div(CLK_HZ, 3'd6), baud_div(CLK_HZ, 3'd7)
    };

    rx_state_t        r_state;
    logic             r_sync1;
    logic             r_sync2;
    logic             r_rx_prev;
    logic [DIVW-1:0]  r_div;
    logic [DIVW-1:0]  r_div_cnt;
    logic [3:0]       r_tick_cnt;
    logic [BW-1:0]    r_bit_idx;
    logic             r_stop_idx;
    logic [DATA_BITS-1:0] r_shift;
    logic             r_ferr;
    logic             r_perr;
    logic             r_push;
    logic [WIDTH-1:0] r_push_data;
    logic [WIDTH-1:0] w_head;
    logic             w_tick;
    logic             w_sample;
    logic             w_bit_end;
    logic             w_fall;

    assign w_tick    = (r_div_cnt == r_div - 1'b1);
    assign w_sample  = w_tick && (r_tick_cnt == 4'd7);
    assign w_bit_end = w_tick && (r_tick_cnt == 4'd15);
    assign w_fall    = r_rx_prev && !r_sync2;

    // Idle-high synchroniser so reset never fakes a start edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1   <= 1'b1;
            r_sync2   <= 1'b1;
            r_rx_prev <= 1'b1;
        end else begin
            r_sync1   <= RxD;
            r_sync2   <= r_sync1;
            r_rx_prev <= r_sync2;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= S_IDLE;
            r_div       <= DIVW'(DIV_TBL[baud_select]);
            r_div_cnt   <= '0;
            r_tick_cnt  <= '0;
            r_bit_idx   <= '0;
            r_stop_idx  <= 1'b0;
            r_shift     <= '0;
            r_ferr      <= 1'b0;
            r_perr      <= 1'b0;
            r_push      <= 1'b0;
            r_push_data <= '0;
        end else begin
            r_push <= 1'b0;
            if (r_state != S_IDLE) begin
                if (w_tick) begin
                    r_div_cnt  <= '0;
                    r_tick_cnt <= r_tick_cnt + 1'b1;
                end else begin
                    r_div_cnt <= r_div_cnt + 1'b1;
                end
            end
            case (r_state)
                S_IDLE: begin
                    // Divisor only reloads between frames.
                    r_div      <= DIVW'(DIV_TBL[baud_select]);
                    r_div_cnt  <= '0;
                    r_tick_cnt <= '0;
                    if (RX_EN && w_fall) begin
                        r_state    <= S_START;
                        r_bit_idx  <= '0;
                        r_stop_idx <= 1'b0;
                        r_ferr     <= 1'b0;
                        r_perr     <= 1'b0;
                    end
                end
                S_START: begin
                    if (w_sample && r_sync2) begin
                        r_state <= S_IDLE;
                    end else if (w_bit_end) begin
                        r_state <= S_DATA;
                    end
                end
                S_DATA: begin
                    if (w_sample) begin
                        r_shift <= {r_sync2, r_shift[DATA_BITS-1:1]};
                    end
                    if (w_bit_end) begin
                        if (r_bit_idx == BW'(DATA_BITS - 1)) begin
                            r_state <= (PARITY_MODE == PAR_NONE)
                                       ? S_STOP : S_PARITY;
                        end else begin
                            r_bit_idx <= r_bit_idx + 1'b1;
                        end
                    end
                end
                S_PARITY: begin
                    if (w_sample) begin
                        r_perr <= (^{r_shift, r_sync2})
                                  ^ (PARITY_MODE == PAR_ODD);
                    end
                    if (w_bit_end) begin
                        r_state <= S_STOP;
                    end
                end
                S_STOP: begin
                    if (w_sample && !r_sync2) begin
                        r_ferr <= 1'b1;
                    end
                    if (w_bit_end) begin
                        if (r_stop_idx == 1'(STOP_BITS - 1)) begin
                            r_push      <= 1'b1;
                            r_push_data <= {r_shift, r_ferr, r_perr};
                            r_state     <= S_IDLE;
                        end else begin
                            r_stop_idx <= 1'b1;
                        end
                    end
                end
                default: r_state <= S_IDLE;
            endcase
            if (!RX_EN) begin
                r_state <= S_IDLE;
                r_push  <= 1'b0;
            end
        end
    end

    sync_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk           (clk),
        .reset         (reset),
        .i_wr_en       (r_push),
        .i_wr_data     (r_push_data),
        .i_rd_en       (rd_en),
        .i_clr_overrun (clr_overrun),
        .o_rd_data     (w_head),
        .o_empty       (Rx_EMPTY),
        .o_full        (Rx_FULL),
        .o_count       (Rx_COUNT),
        .o_overrun     (Rx_OVERRUN)
    );

    assign Rx_DATA   = w_head[WIDTH-1:2];
    assign Rx_FERROR = w_head[1];
    assign Rx_PERROR = w_head[0];

endmodule
